dll_lock_sequencer: RTL and testbench
=====================================

// Module: dll_lock_sequencer
// PURPOSE
//  Lock controller for the FMDLL phase-tracking loop. Latches configuration (Sel, N, M) into the loop
//  and drives the PD reset. Runs a 10-bit successive-approximation search on the delay code, verifies
//  lock, then tracks in +/-1 steps. Detects loss of lock and re-acquires; flags a fault on timeout or
//  repeated failure. Sits between system control and the PD/decoder datapath, and supplies Q.
// PARAMETERS
//  CODE_W       10    delay-code width; MSB-first search
//  SETTLE_CYC   8     cycles pd_reset is held after a config load, before searching
//  VERIFY_CNT   4     comparisons in VERIFY; also the max same-direction run allowed there
//  LOSS_THRESH  8     consecutive same-direction comparisons in LOCKED that mean lock is lost
//  TIMEOUT_CYC  1023  max cycles waiting for comp_valid in CONFIG/SEARCH/VERIFY/LOCKED
//  MAX_RETRY    3     SEARCH restarts allowed per start before FAULT
// PORTS
//  clk_ext    in   1       reference clock; single clock domain
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       acquisition request (level sampled each cycle)
//  stop       in   1       abort to IDLE; priority over everything except rst_n
//  cfg_sel    in   2       Sel value latched on an accepted start
//  cfg_n      in   4       N value latched on an accepted start
//  cfg_m      in   2       M value latched on an accepted start
//  comp       in   1       PD result: 1 = delay too long (decrease code), 0 = too short (increase)
//  comp_valid in   1       one-cycle strobe; comp is valid on this cycle
//  sel_o      out  2       latched Sel to the loop
//  n_o        out  4       latched N to the loop
//  m_o        out  2       latched M to the loop
//  q          out  CODE_W  delay code to the decoder/PD
//  pd_reset   out  1       PD reset (active high)
//  busy       out  1       1 in CONFIG, SEARCH, VERIFY
//  locked     out  1       1 only in LOCKED
//  lock_lost  out  1       one-cycle pulse on the LOCKED->SEARCH transition
//  fault      out  1       1 only in FAULT
// BEHAVIOUR
//  Reset: state=IDLE, q=10'h200 (mid-scale), pd_reset=1, sel_o/n_o/m_o=0, busy/locked/lock_lost/fault=0.
//  States: IDLE, CONFIG, SEARCH, VERIFY, LOCKED, FAULT. Every output is registered.
//  IDLE: pd_reset=1. start -> CONFIG; cfg_* latched on the same edge; retry counter cleared.
//  start is accepted in IDLE, LOCKED and FAULT (restarts fully). It is ignored in CONFIG/SEARCH/VERIFY.
//  stop in any state -> IDLE next cycle. q keeps its value; locked/busy/fault drop. stop beats start.
//  CONFIG: pd_reset=1 for SETTLE_CYC cycles. Then -> SEARCH with q=10'h200 and bit index=CODE_W-1.
//  SEARCH: per comp_valid: comp=1 clears the current bit. The next-lower bit is then set.
//    After bit 0 is decided -> VERIFY. Exactly CODE_W comp_valids; q is final on the 10th.
//  pd_reset pulses high for 1 cycle after every accepted comp_valid in SEARCH/VERIFY/LOCKED.
//  comp_valid is ignored when not in SEARCH/VERIFY/LOCKED, and during its own pd_reset cycle.
//  VERIFY/LOCKED tracking: comp=1 -> q-1, comp=0 -> q+1, saturating at 0 and 2^CODE_W-1.
//    A saturated step leaves q unchanged but still counts toward the run.
//  Run counter: +1 when comp equals the previous comp; resets to 1 on a direction change.
//    Cleared on entry to VERIFY and LOCKED.
//  VERIFY: run reaches VERIFY_CNT -> re-search: retry+1, go to SEARCH (q=10'h200), or FAULT if
//    retry is already MAX_RETRY. Otherwise, after VERIFY_CNT comparisons -> LOCKED.
//  LOCKED: run reaches LOSS_THRESH -> lock_lost pulse, locked=0, -> SEARCH (retry+1, same limit).
//  Watchdog: counter cleared on each comp_valid and on every state change. Hitting TIMEOUT_CYC in
//    CONFIG-excluded waiting states -> FAULT. FAULT holds q, pd_reset=1, fault=1 until start/stop.
//  Simultaneous comp_valid and watchdog expiry: comp_valid wins.
// STRUCTURE
//  Package dll_ctrl_pkg: state encoding (3-bit localparams), CODE_W, MID_CODE=10'h200, COMP_DEC=1'b1.
//  One sub-module, dll_code_engine: holds q and the bit index.
//    Modes: load-mid, SAR step, +/-1 saturating step, hold.
//  Top keeps the FSM, the run/retry/watchdog/settle counters and the config latches.
// TESTING
//  1 Reset mid-SEARCH (rst_n low 1 cycle) -> q=10'h200, pd_reset=1, all flags 0, state IDLE.
//  2 Target code 10'h2B7: model comp=(q>target), start -> q=10'h2B7 after 10 comp_valids.
//    Then 4 alternating comps -> locked=1.
//  3 LOCKED, then 8 comp=1 in a row -> lock_lost pulses 1 cycle, locked=0, q reloads to 10'h200.
//  4 Target 10'h3FF: search ends at 10'h3FF; comp=0 in tracking holds 10'h3FF (saturates).
//    Run reaches 4 in VERIFY -> retries; the 4th failure asserts fault.
//  5 Start, then no comp_valid for 1023 cycles in SEARCH -> fault=1. A later start clears it
//    and re-enters CONFIG with the new cfg_n.
//  6 stop and start together in LOCKED -> IDLE; start high during SEARCH leaves the search unaffected.

Source files
------------

// File: rtl/dll_ctrl_pkg.sv
// dll_ctrl_pkg: shared constants, state/mode encodings and the config payload
// type for the FMDLL lock sequencer and its code engine.
package dll_ctrl_pkg;

    localparam int unsigned CODE_W      = 10;
    localparam int unsigned SETTLE_CYC  = 8;
    localparam int unsigned VERIFY_CNT  = 4;
    localparam int unsigned LOSS_THRESH = 8;
    localparam int unsigned TIMEOUT_CYC = 1023;
    localparam int unsigned MAX_RETRY   = 3;

    localparam int unsigned IDX_W    = $clog2(CODE_W);
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned RUN_W    = 4;
    localparam int unsigned VCNT_W   = 3;
    localparam int unsigned RETRY_W  = 2;
    localparam int unsigned WDOG_W   = 10;

    localparam logic [CODE_W-1:0] MID_CODE = 10'h200;
    localparam logic              COMP_DEC = 1'b1;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CONFIG = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    // Code engine operating modes
    localparam logic [1:0] MODE_HOLD     = 2'd0;
    localparam logic [1:0] MODE_LOAD_MID = 2'd1;
    localparam logic [1:0] MODE_SAR      = 2'd2;
    localparam logic [1:0] MODE_STEP     = 2'd3;

    // Loop configuration latched on an accepted start
    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] n;
        logic [1:0] m;
    } dll_cfg_t;

    // States in which the PD comparison strobe is consumed
    function automatic logic is_waiting(input logic [2:0] st);
        return (st == ST_SEARCH) || (st == ST_VERIFY) || (st == ST_LOCKED);
    endfunction

endpackage

// File: rtl/dll_code_engine.sv
// dll_code_engine: owns the delay code q and the SAR bit index.
// Ports:
//   clk_ext, rst_n  clock / async active-low reset
//   mode_i          HOLD, LOAD_MID, SAR step, saturating +/-1 step
//   comp_i          PD decision (1 = decrease)
//   q_o             registered delay code
//   bit_idx_o       bit currently under test in SAR mode
module dll_code_engine
    import dll_ctrl_pkg::*;
(
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              comp_i,
    output logic [CODE_W-1:0] q_o,
    output logic [IDX_W-1:0]  bit_idx_o
);

    logic [CODE_W-1:0] q_q, q_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_m1;

    assign idx_m1 = idx_q - IDX_W'(1);

    // Next code / index per mode
    always_comb begin
        q_d   = q_q;
        idx_d = idx_q;
        case (mode_i)
            MODE_LOAD_MID: begin
                q_d   = MID_CODE;
                idx_d = IDX_W'(CODE_W - 1);
            end
            MODE_SAR: begin
                if (comp_i == COMP_DEC) begin
                    q_d[idx_q] = 1'b0;
                end
                // Trial-set the next lower bit; index parks at 0 once done
                if (idx_q != '0) begin
                    q_d[idx_m1] = 1'b1;
                    idx_d       = idx_m1;
                end
            end
            MODE_STEP: begin
                if (comp_i == COMP_DEC) begin
                    if (q_q != '0) begin
                        q_d = q_q - CODE_W'(1);
                    end
                end else begin
                    if (q_q != '1) begin
                        q_d = q_q + CODE_W'(1);
                    end
                end
            end
            default: begin
                q_d   = q_q;
                idx_d = idx_q;
            end
        endcase
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= MID_CODE;
            idx_q <= IDX_W'(CODE_W - 1);
        end else begin
            q_q   <= q_d;
            idx_q <= idx_d;
        end
    end

    assign q_o       = q_q;
    assign bit_idx_o = idx_q;

endmodule

// File: rtl/dll_lock_sequencer.sv
// dll_lock_sequencer: FMDLL lock controller. Latches loop config, holds PD in
// reset while settling, runs a SAR search on the delay code, verifies lock,
// tracks in +/-1 steps, detects loss of lock and flags faults.
// Ports:
//   clk_ext, rst_n            clock / async active-low reset
//   start, stop               acquisition request / abort to IDLE
//   cfg_sel, cfg_n, cfg_m     config captured on an accepted start
//   comp, comp_valid          PD decision and its strobe
//   sel_o, n_o, m_o           latched config to the loop
//   q                         delay code
//   pd_reset                  PD reset (active high)
//   busy, locked, lock_lost, fault  status (all registered)
module dll_lock_sequencer
    import dll_ctrl_pkg::*;
(
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        cfg_sel,
    input  logic [3:0]        cfg_n,
    input  logic [1:0]        cfg_m,
    input  logic              comp,
    input  logic              comp_valid,
    output logic [1:0]        sel_o,
    output logic [3:0]        n_o,
    output logic [1:0]        m_o,
    output logic [CODE_W-1:0] q,
    output logic              pd_reset,
    output logic              busy,
    output logic              locked,
    output logic              lock_lost,
    output logic              fault
);

    logic [2:0]          state_q, state_d;
    dll_cfg_t            cfg_q, cfg_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [RUN_W-1:0]    run_q, run_d, run_nxt;
    logic                prev_q, prev_d;
    logic [VCNT_W-1:0]   vcnt_q, vcnt_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                pd_reset_q, pd_reset_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic                lock_lost_q, lock_lost_d;
    logic                fault_q, fault_d;

    logic [1:0]          eng_mode;
    logic [IDX_W-1:0]    bit_idx;
    logic                accept;
    logic                restart;
    logic                research;
    logic                wdog_expire;

    dll_code_engine u_engine (
        .clk_ext   (clk_ext),
        .rst_n     (rst_n),
        .mode_i    (eng_mode),
        .comp_i    (comp),
        .q_o       (q),
        .bit_idx_o (bit_idx)
    );

    // A strobe landing in its own pd_reset pulse cycle is dropped
    assign accept      = comp_valid && !pd_reset_q && is_waiting(state_q);
    assign restart     = start && ((state_q == ST_IDLE) || (state_q == ST_LOCKED) ||
                                   (state_q == ST_FAULT));
    assign wdog_expire = (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
    assign run_nxt     = ((run_q == '0) || (comp != prev_q)) ? RUN_W'(1) : run_q + RUN_W'(1);

    // Next-state and counter logic
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        settle_d = settle_q;
        run_d    = run_q;
        prev_d   = prev_q;
        vcnt_d   = vcnt_q;
        retry_d  = retry_q;
        wdog_d   = wdog_q + WDOG_W'(1);
        eng_mode = MODE_HOLD;
        research = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (restart) begin
            state_d  = ST_CONFIG;
            cfg_d    = '{sel: cfg_sel, n: cfg_n, m: cfg_m};
            retry_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) begin
                        state_d  = ST_SEARCH;
                        eng_mode = MODE_LOAD_MID;
                    end else begin
                        settle_d = settle_q + SETTLE_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (accept) begin
                        eng_mode = MODE_SAR;
                        if (bit_idx == '0) begin
                            state_d = ST_VERIFY;
                            run_d   = '0;
                            vcnt_d  = '0;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_VERIFY: begin
                    if (accept) begin
                        eng_mode = MODE_STEP;
                        run_d    = run_nxt;
                        prev_d   = comp;
                        vcnt_d   = vcnt_q + VCNT_W'(1);
                        if (run_nxt == RUN_W'(VERIFY_CNT)) begin
                            research = 1'b1;
                        end else if (vcnt_q + VCNT_W'(1) == VCNT_W'(VERIFY_CNT)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_LOCKED: begin
                    if (accept) begin
                        eng_mode = MODE_STEP;
                        run_d    = run_nxt;
                        prev_d   = comp;
                        if (run_nxt == RUN_W'(LOSS_THRESH)) begin
                            research = 1'b1;
                        end
                    end else if (wdog_expire) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_IDLE, ST_FAULT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Re-acquire from mid-scale, or give up once retries are spent
            if (research) begin
                if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d  = ST_SEARCH;
                    retry_d  = retry_q + RETRY_W'(1);
                    eng_mode = MODE_LOAD_MID;
                end
            end
        end

        if (accept || (state_d != state_q) || !is_waiting(state_q)) begin
            wdog_d = '0;
        end
    end

    // Registered status derived from the next state
    always_comb begin
        pd_reset_d  = (state_d == ST_IDLE) || (state_d == ST_CONFIG) ||
                      (state_d == ST_FAULT) || accept;
        busy_d      = (state_d == ST_CONFIG) || (state_d == ST_SEARCH) ||
                      (state_d == ST_VERIFY);
        locked_d    = (state_d == ST_LOCKED);
        fault_d     = (state_d == ST_FAULT);
        lock_lost_d = research && (state_q == ST_LOCKED) && (state_d == ST_SEARCH);
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            settle_q    <= '0;
            run_q       <= '0;
            prev_q      <= 1'b0;
            vcnt_q      <= '0;
            retry_q     <= '0;
            wdog_q      <= '0;
            pd_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            settle_q    <= settle_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            vcnt_q      <= vcnt_d;
            retry_q     <= retry_d;
            wdog_q      <= wdog_d;
            pd_reset_q  <= pd_reset_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            fault_q     <= fault_d;
        end
    end

    assign sel_o     = cfg_q.sel;
    assign n_o       = cfg_q.n;
    assign m_o       = cfg_q.m;
    assign pd_reset  = pd_reset_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_dll_lock_sequencer.sv
// tb_dll_lock_sequencer: randomized scenario bench for dll_lock_sequencer with
// a behavioural model (binary search on a target, saturating tracking, run
// history) kept in the bench.
module tb_dll_lock_sequencer;

    logic       clk_ext = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [1:0] cfg_sel, cfg_m;
    logic [3:0] cfg_n;
    logic       comp, comp_valid;
    logic [1:0] sel_o, m_o;
    logic [3:0] n_o;
    logic [9:0] q;
    logic       pd_reset, busy, locked, lock_lost, fault;

    int errors = 0;
    int checks = 0;

    dll_lock_sequencer dut (
        .clk_ext    (clk_ext),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_sel    (cfg_sel),
        .cfg_n      (cfg_n),
        .cfg_m      (cfg_m),
        .comp       (comp),
        .comp_valid (comp_valid),
        .sel_o      (sel_o),
        .n_o        (n_o),
        .m_o        (m_o),
        .q          (q),
        .pd_reset   (pd_reset),
        .busy       (busy),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .fault      (fault)
    );

    always #5 clk_ext = ~clk_ext;

    function automatic int sat_step(input int qv, input logic c);
        if (c) return (qv == 0) ? 0 : qv - 1;
        return (qv == 1023) ? 1023 : qv + 1;
    endfunction

    // Wait for the PD to be out of reset, then strobe one comparison
    task automatic send_comp(input logic c);
        int w;
        w = 0;
        while (pd_reset !== 1'b0 && w < 100) begin
            @(negedge clk_ext);
            w++;
        end
        checks++;
        if (w >= 100) begin
            errors++;
            $display("FAIL send_comp_wait: pd_reset=%b, required 0 within 100 cycles", pd_reset);
        end
        comp_valid = 1'b1;
        comp       = c;
        @(negedge clk_ext);
        comp_valid = 1'b0;
    endtask

    task automatic start_acq(input logic [1:0] s, input logic [3:0] n, input logic [1:0] m,
                             output int cfg_cyc);
        cfg_sel = s; cfg_n = n; cfg_m = m;
        start = 1'b1;
        @(negedge clk_ext);
        start = 1'b0;
        cfg_cyc = 0;
        while (pd_reset === 1'b1 && busy === 1'b1 && cfg_cyc < 50) begin
            cfg_cyc++;
            @(negedge clk_ext);
        end
    endtask

    // Binary search: keep a trial bit whenever the trial code is not above target
    task automatic do_search(input int target);
        int base, cand;
        logic c;
        base = 0;
        for (int b = 9; b >= 0; b--) begin
            cand = base + (1 << b);
            c    = (cand > target);
            send_comp(c);
            if (!c) base = cand;
        end
    endtask

    task automatic do_verify_alt(input int start_q, output int mq);
        logic c;
        mq = start_q;
        for (int k = 0; k < 4; k++) begin
            c = (k % 2 == 1);
            send_comp(c);
            mq = sat_step(mq, c);
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk_ext);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_ext);
        rst_n = 1'b1;
        @(negedge clk_ext);
        checks++;
        if (q !== 10'h200 || pd_reset !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 ||
            lock_lost !== 1'b0 || fault !== 1'b0 || sel_o !== 2'd0 || n_o !== 4'd0 || m_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: q=%h pd=%b busy=%b lk=%b ll=%b f=%b sel=%h n=%h m=%h, required q=200 pd=1 rest 0",
                     q, pd_reset, busy, locked, lock_lost, fault, sel_o, n_o, m_o);
        end
        // Reset in the middle of a search
        start_acq(2'd1, 4'd6, 2'd2, cyc);
        send_comp(1'b0);
        send_comp(1'b1);
        send_comp(1'b0);
        rst_n = 1'b0;
        @(negedge clk_ext);
        rst_n = 1'b1;
        @(negedge clk_ext);
        checks++;
        if (q !== 10'h200 || pd_reset !== 1'b1 || busy !== 1'b0 || locked !== 1'b0 ||
            lock_lost !== 1'b0 || fault !== 1'b0 || n_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_search: q=%h pd=%b busy=%b lk=%b f=%b n=%h, required q=200 pd=1 busy=0 lk=0 f=0 n=0",
                     q, pd_reset, busy, locked, fault, n_o);
        end
        repeat (5) @(negedge clk_ext);
        checks++;
        if (busy !== 1'b0 || pd_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b pd=%b, required busy=0 pd=1", busy, pd_reset);
        end
    endtask

    task automatic test_lock_2b7();
        int cyc, base, cand, expq, mq;
        logic c;
        logic [1:0] s, m;
        logic [3:0] n;
        s = 2'($urandom_range(0, 3));
        n = 4'($urandom_range(0, 15));
        m = 2'($urandom_range(0, 3));
        start_acq(s, n, m, cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL config_settle: cycles=%0d, required 8", cyc);
        end
        checks++;
        if (sel_o !== s || n_o !== n || m_o !== m || busy !== 1'b1 || q !== 10'h200) begin
            errors++;
            $display("FAIL config_latch: sel=%h n=%h m=%h busy=%b q=%h, required sel=%h n=%h m=%h busy=1 q=200",
                     sel_o, n_o, m_o, busy, q, s, n, m);
        end
        base = 0;
        for (int b = 9; b >= 0; b--) begin
            cand = base + (1 << b);
            c    = (cand > 'h2B7);
            send_comp(c);
            if (!c) base = cand;
            expq = (b > 0) ? base + (1 << (b - 1)) : base;
            checks++;
            if (q !== 10'(expq) || busy !== 1'b1) begin
                errors++;
                $display("FAIL sar_step%0d: q=%h busy=%b, required q=%h busy=1", b, q, busy, 10'(expq));
            end
            if (b == 9) begin
                // Strobe during the pd_reset pulse must be ignored
                comp_valid = 1'b1;
                comp       = 1'b1;
                @(negedge clk_ext);
                comp_valid = 1'b0;
                checks++;
                if (q !== 10'(expq)) begin
                    errors++;
                    $display("FAIL ignore_in_pd_reset: q=%h, required %h", q, 10'(expq));
                end
            end
        end
        mq = 'h2B7;
        for (int k = 0; k < 4; k++) begin
            c = (k % 2 == 1);
            send_comp(c);
            mq = sat_step(mq, c);
            checks++;
            if (q !== 10'(mq) || locked !== (k == 3) || busy !== (k != 3)) begin
                errors++;
                $display("FAIL verify%0d: q=%h locked=%b busy=%b, required q=%h locked=%b busy=%b",
                         k, q, locked, busy, 10'(mq), (k == 3), (k != 3));
            end
        end
    endtask

    task automatic test_lock_loss();
        int mq;
        mq = 'h2B7;
        for (int k = 1; k <= 8; k++) begin
            send_comp(1'b1);
            mq = sat_step(mq, 1'b1);
            checks++;
            if (k < 8) begin
                if (locked !== 1'b1 || lock_lost !== 1'b0 || q !== 10'(mq)) begin
                    errors++;
                    $display("FAIL track_dec%0d: q=%h locked=%b ll=%b, required q=%h locked=1 ll=0",
                             k, q, locked, lock_lost, 10'(mq));
                end
            end else if (lock_lost !== 1'b1 || locked !== 1'b0 || q !== 10'h200 || busy !== 1'b1) begin
                errors++;
                $display("FAIL lock_lost_edge: ll=%b locked=%b q=%h busy=%b, required ll=1 locked=0 q=200 busy=1",
                         lock_lost, locked, q, busy);
            end
        end
        @(negedge clk_ext);
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL lock_lost_pulse_width: ll=%b, required 0", lock_lost);
        end
        pulse_stop();
        checks++;
        if (busy !== 1'b0 || q !== 10'h200 || pd_reset !== 1'b1) begin
            errors++;
            $display("FAIL stop_after_loss: busy=%b q=%h pd=%b, required busy=0 q=200 pd=1", busy, q, pd_reset);
        end
    endtask

    task automatic test_random_track();
        for (int it = 0; it < 3; it++) begin
            int   target, mq, cyc;
            logic c;
            logic hist[$];
            bit   lost;
            target = int'($urandom_range(0, 1023));
            start_acq(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), cyc);
            do_search(target);
            do_verify_alt(target, mq);
            checks++;
            if (locked !== 1'b1 || q !== 10'(mq)) begin
                errors++;
                $display("FAIL rand_lock%0d: target=%h locked=%b q=%h, required locked=1 q=%h",
                         it, 10'(target), locked, q, 10'(mq));
            end
            lost = 1'b0;
            c    = 1'($urandom_range(0, 1));
            for (int k = 0; k < 30 && !lost; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) c = ~c;
                send_comp(c);
                mq = sat_step(mq, c);
                hist.push_back(c);
                lost = (hist.size() >= 8);
                if (lost) begin
                    for (int j = hist.size() - 8; j < hist.size(); j++) begin
                        if (hist[j] !== c) lost = 1'b0;
                    end
                end
                checks++;
                if (lost) begin
                    if (lock_lost !== 1'b1 || locked !== 1'b0 || q !== 10'h200) begin
                        errors++;
                        $display("FAIL rand_loss%0d_%0d: ll=%b locked=%b q=%h, required ll=1 locked=0 q=200",
                                 it, k, lock_lost, locked, q);
                    end
                end else if (locked !== 1'b1 || lock_lost !== 1'b0 || q !== 10'(mq)) begin
                    errors++;
                    $display("FAIL rand_track%0d_%0d: locked=%b ll=%b q=%h, required locked=1 ll=0 q=%h",
                             it, k, locked, lock_lost, q, 10'(mq));
                end
            end
            pulse_stop();
        end
    endtask

    task automatic test_saturate_fault();
        int cyc;
        start_acq(2'd2, 4'd9, 2'd1, cyc);
        for (int a = 0; a < 4; a++) begin
            do_search('h3FF);
            checks++;
            if (q !== 10'h3FF) begin
                errors++;
                $display("FAIL sat_search%0d: q=%h, required 3ff", a, q);
            end
            for (int k = 0; k < 4; k++) begin
                send_comp(1'b0);
                checks++;
                if (k < 3) begin
                    if (q !== 10'h3FF || locked !== 1'b0) begin
                        errors++;
                        $display("FAIL sat_hold%0d_%0d: q=%h locked=%b, required q=3ff locked=0", a, k, q, locked);
                    end
                end else if (a < 3) begin
                    if (busy !== 1'b1 || fault !== 1'b0 || q !== 10'h200) begin
                        errors++;
                        $display("FAIL retry%0d: busy=%b fault=%b q=%h, required busy=1 fault=0 q=200",
                                 a, busy, fault, q);
                    end
                end else if (fault !== 1'b1 || busy !== 1'b0 || pd_reset !== 1'b1 || q !== 10'h3FF) begin
                    errors++;
                    $display("FAIL retry_fault: fault=%b busy=%b pd=%b q=%h, required fault=1 busy=0 pd=1 q=3ff",
                             fault, busy, pd_reset, q);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        start_acq(2'd0, 4'h5, 2'd0, cyc);
        checks++;
        if (fault !== 1'b0 || cyc !== 8 || n_o !== 4'h5) begin
            errors++;
            $display("FAIL fault_restart: fault=%b cfg_cycles=%0d n=%h, required fault=0 cycles=8 n=5", fault, cyc, n_o);
        end
        repeat (1022) @(negedge clk_ext);
        checks++;
        if (fault !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wdog_early: fault=%b busy=%b, required fault=0 busy=1", fault, busy);
        end
        @(negedge clk_ext);
        checks++;
        if (fault !== 1'b1 || busy !== 1'b0 || pd_reset !== 1'b1 || q !== 10'h200) begin
            errors++;
            $display("FAIL wdog_fault: fault=%b busy=%b pd=%b q=%h, required fault=1 busy=0 pd=1 q=200",
                     fault, busy, pd_reset, q);
        end
        cfg_n = 4'hA;
        start = 1'b1;
        @(negedge clk_ext);
        start = 1'b0;
        checks++;
        if (fault !== 1'b0 || busy !== 1'b1 || n_o !== 4'hA || pd_reset !== 1'b1) begin
            errors++;
            $display("FAIL wdog_clear: fault=%b busy=%b n=%h pd=%b, required fault=0 busy=1 n=a pd=1",
                     fault, busy, n_o, pd_reset);
        end
        pulse_stop();
    endtask

    task automatic test_stop_start();
        int cyc, target, mq;
        target = int'($urandom_range(16, 1000));
        start_acq(2'd3, 4'd7, 2'd3, cyc);
        do_search(target);
        do_verify_alt(target, mq);
        checks++;
        if (locked !== 1'b1 || q !== 10'(target)) begin
            errors++;
            $display("FAIL ss_lock: locked=%b q=%h, required locked=1 q=%h", locked, q, 10'(target));
        end
        stop = 1'b1; start = 1'b1;
        @(negedge clk_ext);
        stop = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || locked !== 1'b0 || fault !== 1'b0 || pd_reset !== 1'b1 || q !== 10'(target)) begin
            errors++;
            $display("FAIL stop_beats_start: busy=%b locked=%b fault=%b pd=%b q=%h, required 0 0 0 1 q=%h",
                     busy, locked, fault, pd_reset, q, 10'(target));
        end
        // start held high through CONFIG and SEARCH must not disturb them
        target = int'($urandom_range(16, 1000));
        cfg_n = 4'h3;
        start = 1'b1;
        @(negedge clk_ext);
        cfg_n = 4'hC;
        do_search(target);
        checks++;
        if (q !== 10'(target) || busy !== 1'b1 || locked !== 1'b0 || n_o !== 4'h3) begin
            errors++;
            $display("FAIL start_ignored: q=%h busy=%b locked=%b n=%h, required q=%h busy=1 locked=0 n=3",
                     q, busy, locked, n_o, 10'(target));
        end
        start = 1'b0;
        do_verify_alt(target, mq);
        checks++;
        if (locked !== 1'b1 || q !== 10'(mq)) begin
            errors++;
            $display("FAIL ss_relock: locked=%b q=%h, required locked=1 q=%h", locked, q, 10'(mq));
        end
        pulse_stop();
    endtask

    initial begin
        start = 1'b0; stop = 1'b0; comp = 1'b0; comp_valid = 1'b0;
        cfg_sel = '0; cfg_n = '0; cfg_m = '0;
        rst_n = 1'b0;
        @(negedge clk_ext);
        test_reset();
        test_lock_2b7();
        test_lock_loss();
        test_random_track();
        test_saturate_fault();
        test_timeout();
        test_stop_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench time limit");
    end

endmodule
